pipeline_data_mem: RTL and testbench

//  Data-memory responder on the far end of the MEM-stage dm_* interface. Accepts one

---
 rtl/pipeline_data_mem.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_data_mem.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_data_mem.sv
// RV64 data-memory responder: byte-lane store merge, sign/zero-extended loads, optional wait states.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module pipeline_data_mem #(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int WAIT_STATES    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_dout,
    output logic        dm_busy,
    output logic        dm_done,
    output logic        dm_fault
);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int AW    = MEM_DEPTH_LOG2 + 3;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic          busy_reg, done_reg, fault_reg;
    logic [63:0]   dout_reg;
    logic [AW-1:0] addr_reg;
    logic [63:0]   din_reg;
    logic          store_reg, sgn_reg;
    logic [1:0]    size_reg;

    logic          in_store, in_req, in_sgn;
    logic [1:0]    in_size;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^dm_addr[63:AW];

    // Size is log2 of the access width in bytes; a store request overrides any load.
    always_comb begin
        in_store = dm_wr_ctrl inside {3'd1, 3'd2, 3'd3, 3'd4};
        in_req   = in_store || (dm_rd_ctrl != 3'd0);
        in_sgn   = 1'b0;
        in_size  = 2'd0;
        if (in_store) begin
            in_size = 2'(dm_wr_ctrl - 3'd1);
        end else begin
            case (dm_rd_ctrl)
                3'd1:    begin in_size = 2'd0; in_sgn = 1'b1; end
                3'd2:    in_size = 2'd0;
                3'd3:    begin in_size = 2'd1; in_sgn = 1'b1; end
                3'd4:    in_size = 2'd1;
                3'd5:    begin in_size = 2'd2; in_sgn = 1'b1; end
                3'd6:    in_size = 2'd2;
                3'd7:    in_size = 2'd3;
                default: in_size = 2'd0;
            endcase
        end
    end

    logic          in_wait, complete;
    logic [AW-1:0] cur_addr;
    logic [63:0]   cur_din;
    logic          cur_store, cur_sgn, cur_fault;
    logic [1:0]    cur_size;
    logic [2:0]    cur_off, eff_off, size_mask;
    logic [MEM_DEPTH_LOG2-1:0] idx;

    assign in_wait   = (state_reg == WAIT);
    assign cur_addr  = in_wait ? addr_reg  : dm_addr[AW-1:0];
    assign cur_din   = in_wait ? din_reg   : dm_din;
    assign cur_store = in_wait ? store_reg : in_store;
    assign cur_sgn   = in_wait ? sgn_reg   : in_sgn;
    assign cur_size  = in_wait ? size_reg  : in_size;
    assign complete  = in_wait ? (cnt_reg == 4'd0) : (in_req && (WAIT_STATES == 0));
    assign cur_off   = cur_addr[2:0];
    assign idx       = cur_addr[AW-1:3];

    always_comb begin
        case (cur_size)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign cur_fault = (cur_off & size_mask) != 3'd0;
    assign eff_off   = cur_off;
`else
    assign cur_fault = 1'b0;
    assign eff_off   = cur_off & ~size_mask;
`endif

    logic [7:0]  lane_mask, byte_en;
    logic [63:0] wdata, rd_word, rd_shift, load_value;
    logic        wr_en;

    always_comb begin
        case (cur_size)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    assign byte_en = lane_mask << eff_off;
    assign wdata   = cur_din << {eff_off, 3'b000};
    // Reset on the completion edge must drop the pending store.
    assign wr_en   = complete && cur_store && !cur_fault && !reset;

    // One byte-wide array per lane so sub-word stores need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            always_ff @(posedge clk) begin
                if (wr_en && byte_en[gi])
                    lane_mem[idx] <= wdata[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate

    assign rd_shift = rd_word >> {eff_off, 3'b000};

    always_comb begin
        case (cur_size)
            2'd0:    load_value = cur_sgn ? {{56{rd_shift[7]}},  rd_shift[7:0]}  : {56'd0, rd_shift[7:0]};
            2'd1:    load_value = cur_sgn ? {{48{rd_shift[15]}}, rd_shift[15:0]} : {48'd0, rd_shift[15:0]};
            2'd2:    load_value = cur_sgn ? {{32{rd_shift[31]}}, rd_shift[31:0]} : {32'd0, rd_shift[31:0]};
            default: load_value = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            dout_reg  <= 64'd0;
            addr_reg  <= '0;
            din_reg   <= 64'd0;
            store_reg <= 1'b0;
            sgn_reg   <= 1'b0;
            size_reg  <= 2'd0;
        end else begin
            done_reg  <= complete;
            fault_reg <= complete && cur_fault;
            if (complete) begin
                if (cur_fault)
                    dout_reg <= 64'd0;
                else if (!cur_store)
                    dout_reg <= load_value;
            end
            case (state_reg)
                IDLE: begin
                    if (in_req && (WAIT_STATES != 0)) begin
                        state_reg <= WAIT;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= CNT_INIT;
                        addr_reg  <= dm_addr[AW-1:0];
                        din_reg   <= dm_din;
                        store_reg <= in_store;
                        sgn_reg   <= in_sgn;
                        size_reg  <= in_size;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dm_dout  = dout_reg;
    assign dm_busy  = busy_reg;
    assign dm_done  = done_reg;
    assign dm_fault = fault_reg;
endmodule

// File: tb/tb_pipeline_data_mem.sv
// Scoreboard bench: instance a runs with no wait states, instance b with three.
module tb_pipeline_data_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_reset, a_busy, a_done, a_fault;
    logic [63:0] a_addr, a_din, a_dout;
    logic [2:0]  a_rd, a_wr;
    logic        b_reset, b_busy, b_done, b_fault;
    logic [63:0] b_addr, b_din, b_dout;
    logic [2:0]  b_rd, b_wr;

    pipeline_data_mem #(.MEM_DEPTH_LOG2(10), .WAIT_STATES(0)) dut_a (
        .clk(clk), .reset(a_reset), .dm_addr(a_addr), .dm_din(a_din),
        .dm_rd_ctrl(a_rd), .dm_wr_ctrl(a_wr), .dm_dout(a_dout),
        .dm_busy(a_busy), .dm_done(a_done), .dm_fault(a_fault));

    pipeline_data_mem #(.MEM_DEPTH_LOG2(10), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset(b_reset), .dm_addr(b_addr), .dm_din(b_din),
        .dm_rd_ctrl(b_rd), .dm_wr_ctrl(b_wr), .dm_dout(b_dout),
        .dm_busy(b_busy), .dm_done(b_done), .dm_fault(b_fault));

    typedef struct {
        int          cyc;
        logic [63:0] dout;
        logic        fault;
        string       name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_chk  = 0;
    int n_fail = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%016h", name, act);
        end
    endtask

    // Monitors: pop the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!a_reset) begin
            if (a_fault && !a_done) check("a_fault_without_done", 64'(a_fault), 64'd0);
            if (a_done) begin : pop_a
                exp_t e;
                if (qa.size() == 0) begin
                    check("a_unexpected_done", 64'(a_done), 64'd0);
                end else begin
                    e = qa.pop_front();
                    check({e.name, "_dout"},  a_dout, e.dout);
                    check({e.name, "_fault"}, 64'(a_fault), 64'(e.fault));
                    check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_busy"},  64'(a_busy), 64'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!b_reset) begin
            if (b_fault && !b_done) check("b_fault_without_done", 64'(b_fault), 64'd0);
            if (b_done) begin : pop_b
                exp_t e;
                if (qb.size() == 0) begin
                    check("b_unexpected_done", 64'(b_done), 64'd0);
                end else begin
                    e = qb.pop_front();
                    check({e.name, "_dout"},  b_dout, e.dout);
                    check({e.name, "_fault"}, 64'(b_fault), 64'(e.fault));
                    check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic a_issue(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                           input logic [63:0] din, input bit expect_done,
                           input logic [63:0] exp_dout, input logic exp_fault, input string name);
        exp_t e;
        @(posedge clk); #1;
        a_rd = rd; a_wr = wr; a_addr = addr; a_din = din;
        if (expect_done) begin
            e.cyc = cyc + 1; e.dout = exp_dout; e.fault = exp_fault; e.name = name;
            qa.push_back(e);
        end
    endtask

    task automatic b_issue(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                           input logic [63:0] din, input bit expect_done,
                           input logic [63:0] exp_dout, input string name);
        exp_t e;
        @(posedge clk); #1;
        b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
        if (expect_done) begin
            e.cyc = cyc + 1 + 3; e.dout = exp_dout; e.fault = 1'b0; e.name = name;
            qb.push_back(e);
        end
    endtask

    task automatic a_idle();
        @(posedge clk); #1;
        a_rd = 3'd0; a_wr = 3'd0;
    endtask

    task automatic b_idle();
        @(posedge clk); #1;
        b_rd = 3'd0; b_wr = 3'd0;
    endtask

    task automatic drain(input bit use_b, input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((use_b ? qb.size() : qa.size()) == 0) break;
        end
        check(name, 64'(use_b ? qb.size() : qa.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        a_reset = 1'b1; a_addr = '0; a_din = '0; a_rd = '0; a_wr = '0;
        b_reset = 1'b1; b_addr = '0; b_din = '0; b_rd = '0; b_wr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_dout",  a_dout, 64'd0);
        check("a_reset_busy",  64'(a_busy), 64'd0);
        check("a_reset_done",  64'(a_done), 64'd0);
        check("a_reset_fault", 64'(a_fault), 64'd0);
        check("b_reset_dout",  b_dout, 64'd0);
        check("b_reset_busy",  64'(b_busy), 64'd0);
        check("b_reset_done",  64'(b_done), 64'd0);
        check("b_reset_fault", 64'(b_fault), 64'd0);
        @(posedge clk); #1;
        a_reset = 1'b0; b_reset = 1'b0;

        // Zero-wait instance, every access back to back.
        a_issue(3'd0, 3'd4, 64'h10, 64'h8877665544332211, 1, 64'h0, 0, "sd_10");
        a_issue(3'd7, 3'd0, 64'h10, 64'h0, 1, 64'h8877665544332211, 0, "ld_10");
        a_issue(3'd0, 3'd1, 64'h13, 64'hFFFFFFFFFFFFFFAA, 1, 64'h8877665544332211, 0, "sb_13");
        a_issue(3'd1, 3'd0, 64'h13, 64'h0, 1, 64'hFFFFFFFFFFFFFFAA, 0, "lb_13");
        a_issue(3'd2, 3'd0, 64'h13, 64'h0, 1, 64'h00000000000000AA, 0, "lbu_13");
        a_issue(3'd5, 3'd0, 64'h10, 64'h0, 1, 64'hFFFFFFFFAA332211, 0, "lw_10");
        a_issue(3'd3, 3'd0, 64'h16, 64'h0, 1, 64'hFFFFFFFFFFFF8877, 0, "lh_16");
        a_issue(3'd4, 3'd0, 64'h16, 64'h0, 1, 64'h0000000000008877, 0, "lhu_16");
        a_issue(3'd5, 3'd0, 64'h14, 64'h0, 1, 64'hFFFFFFFF88776655, 0, "lw_14");
        a_issue(3'd6, 3'd0, 64'h14, 64'h0, 1, 64'h0000000088776655, 0, "lwu_14");
        a_issue(3'd0, 3'd3, 64'h8,  64'h11112222DEADBEEF, 1, 64'h0000000088776655, 0, "sw_08");
        a_issue(3'd6, 3'd0, 64'h8,  64'h0, 1, 64'h00000000DEADBEEF, 0, "lwu_08_raw");
        a_issue(3'd7, 3'd1, 64'h10, 64'h55, 1, 64'h00000000DEADBEEF, 0, "ld_sb_store_wins");
        a_issue(3'd7, 3'd0, 64'h10, 64'h0, 1, 64'h88776655AA332255, 0, "ld_10_after_sb");
        a_issue(3'd7, 3'd0, 64'h8000000000002010, 64'h0, 1, 64'h88776655AA332255, 0, "ld_wrap");
        a_issue(3'd0, 3'd5, 64'h10, 64'h0, 0, 64'h0, 0, "reserved_wr");
        a_issue(3'd3, 3'd0, 64'h11, 64'h0, 1, TRAP ? 64'h0 : 64'h0000000000002255, TRAP, "lh_11_misaligned");
        a_issue(3'd0, 3'd2, 64'h13, 64'h1234, 1, TRAP ? 64'h0 : 64'h0000000000002255, TRAP, "sh_13_misaligned");
        a_issue(3'd7, 3'd0, 64'h10, 64'h0, 1, TRAP ? 64'h88776655AA332255 : 64'h8877665512342255, 0, "ld_10_final");
        a_idle();
        drain(0, "a_drain");

        // Three-wait instance: latency, busy window, ignored request, back-to-back.
        b_issue(3'd0, 3'd4, 64'h20, 64'h0123456789ABCDEF, 1, 64'h0, "b_sd_20");
        b_idle();
        drain(1, "b_drain_sd");

        b_issue(3'd7, 3'd0, 64'h20, 64'h0, 1, 64'h0123456789ABCDEF, "b_ld_20");
        @(posedge clk); #1; b_rd = 3'd0;
        @(negedge clk); check("b_busy_t0", 64'(b_busy), 64'd1);
        @(posedge clk); #1; b_wr = 3'd4; b_addr = 64'h20; b_din = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk); check("b_busy_t1", 64'(b_busy), 64'd1);
        @(posedge clk); #1; b_wr = 3'd0;
        @(negedge clk); check("b_busy_t2", 64'(b_busy), 64'd1);
        b_issue(3'd7, 3'd0, 64'h20, 64'h0, 1, 64'h0123456789ABCDEF, "b_ld_20_b2b");
        @(negedge clk); check("b_busy_done_cycle", 64'(b_busy), 64'd0);
        @(posedge clk); #1; b_rd = 3'd0;
        @(negedge clk); check("b_busy_b2b_accept", 64'(b_busy), 64'd1);
        drain(1, "b_drain_ld");

        // Reset lands on the store's completion edge: nothing may be written.
        b_issue(3'd0, 3'd4, 64'h20, 64'hCAFEBABE00000000, 0, 64'h0, "b_sd_reset");
        @(posedge clk); #1; b_wr = 3'd0;
        @(posedge clk);
        @(posedge clk); #1; b_reset = 1'b1;
        @(negedge clk); check("b_busy_before_reset", 64'(b_busy), 64'd1);
        @(negedge clk);
        check("b_reset_mid_busy", 64'(b_busy), 64'd0);
        check("b_reset_mid_done", 64'(b_done), 64'd0);
        check("b_reset_mid_dout", b_dout, 64'd0);
        @(posedge clk); #1; b_reset = 1'b0;
        b_issue(3'd7, 3'd0, 64'h20, 64'h0, 1, 64'h0123456789ABCDEF, "b_ld_20_after_reset");
        b_idle();
        drain(1, "b_drain_final");

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
